// File: rtl/life_step_engine_pkg.sv
// Shared types and constants for the 8x8 Game of Life generation engine.
// Tap indices locate each neighbour inside the rotating window, whose MSB is the centre cell.
package life_pkg;

  localparam int BOARD_W = 64;
  localparam int CNT_W   = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int C  = 63;
  localparam int R  = 0;
  localparam int L  = 62;
  localparam int D  = 7;
  localparam int U  = 55;
  localparam int RD = 8;
  localparam int LD = 6;
  localparam int RU = 56;
  localparam int LU = 54;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s = s + {3'b000, v[i]};
    end
    return s;
  endfunction

endpackage

// File: rtl/life_step_engine_rule.sv
// Combinational B3/S23 rule for the centre cell of the window.
// Border taps are forced to 0 so the board never wraps.
module life_rule
  import life_pkg::*;
(
  input  logic [BOARD_W-1:0] win,
  input  logic [CNT_W-1:0]   cnt,
  output logic               nxt
);

  logic [2:0] x;
  logic [2:0] y;
  logic       has_r;
  logic       has_l;
  logic       has_d;
  logic       has_u;
  logic [7:0] nb;
  logic [3:0] n;

  assign x = cnt[2:0];
  assign y = cnt[5:3];

  always_comb begin
    has_r = (x != 3'd7);
    has_l = (x != 3'd0);
    has_d = (y != 3'd7);
    has_u = (y != 3'd0);

    nb[0] = win[R]  & has_r;
    nb[1] = win[L]  & has_l;
    nb[2] = win[D]  & has_d;
    nb[3] = win[U]  & has_u;
    nb[4] = win[RD] & has_r & has_d;
    nb[5] = win[LD] & has_l & has_d;
    nb[6] = win[RU] & has_r & has_u;
    nb[7] = win[LU] & has_l & has_u;

    n   = popcount8(nb);
    nxt = (n == 4'd3) | (win[C] & (n == 4'd2));
  end

endmodule

// File: rtl/life_step_engine.sv
// Sequential Game of Life engine: walks the 64 cells of a board snapshot one per
// enabled cycle through a rotating window and publishes the next generation.
module life_step_engine
  import life_pkg::*;
#(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   en,
  input  logic [X*Y-1:0]         board_in,
  output logic [X*Y-1:0]         board_out,
  output logic                   busy,
  output logic                   done,
  output logic [LOG2X+LOG2Y-1:0] cnt
);

  state_e             state_q, state_d;
  logic [BOARD_W-1:0] win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BOARD_W-1:0] result_q, result_d;
  logic [BOARD_W-1:0] board_out_q, board_out_d;
  logic               done_q, done_d;
  logic               nxt;

  life_rule u_rule (
    .win (win_q),
    .cnt (cnt_q),
    .nxt (nxt)
  );

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    board_out_d = board_out_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // done_q is high in the first IDLE cycle; a start coinciding with it is dropped.
        if (start && !done_q) begin
          win_d    = {board_in[0], board_in[X*Y-1:1]};
          cnt_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (en) begin
          result_d[cnt_q] = nxt;
          win_d           = {win_q[0], win_q[BOARD_W-1:1]};
          cnt_d           = cnt_q + 6'd1;
          if (cnt_q == {CNT_W{1'b1}}) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        board_out_d = result_q;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      board_out_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      board_out_q <= board_out_d;
      done_q      <= done_d;
    end
  end

  assign board_out = board_out_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign cnt       = cnt_q;

endmodule

// File: tb/tb_life_step_engine.sv
// Bench for life_step_engine: a generation-level reference model checked every cycle,
// plus directed runs with hand-computed boards and latencies.
module tb_life_step_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        en;
  logic [63:0] board_in;
  logic [63:0] board_out;
  logic        busy;
  logic        done;
  logic [5:0]  cnt;

  int n_checks = 0;
  int n_pass   = 0;

  life_step_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .en        (en),
    .board_in  (board_in),
    .board_out (board_out),
    .busy      (busy),
    .done      (done),
    .cnt       (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Next generation straight from the rules: count in-board live neighbours.
  function automatic logic [63:0] life_next(input logic [63:0] b);
    logic [63:0] r;
    int n, nx, ny;
    r = '0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            nx = x + dx;
            ny = y + dy;
            if ((dx != 0 || dy != 0) && nx >= 0 && nx < 8 && ny >= 0 && ny < 8)
              if (b[ny*8+nx]) n++;
          end
        end
        r[y*8+x] = (n == 3) || (b[y*8+x] && n == 2);
      end
    end
    return r;
  endfunction

  // Transaction-level model: -1 = no generation in flight, else enabled steps taken.
  int          m_steps = -1;
  logic        m_done  = 1'b0;
  logic [63:0] m_out   = '0;
  logic [63:0] m_snap  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_steps <= -1;
      m_done  <= 1'b0;
      m_out   <= '0;
      m_snap  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_steps < 0) begin
        if (start && !m_done) begin
          m_snap  <= board_in;
          m_steps <= 0;
        end
      end else if (m_steps == 64) begin
        m_out   <= life_next(m_snap);
        m_done  <= 1'b1;
        m_steps <= -1;
      end else if (en) begin
        m_steps <= m_steps + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", {63'b0, busy}, {63'b0, (m_steps >= 0)});
    check("cyc_done", {63'b0, done}, {63'b0, m_done});
    check("cyc_cnt", {58'b0, cnt}, (m_steps < 0) ? 64'd0 : 64'(m_steps % 64));
    check("cyc_board_out", board_out, m_out);
  end

  // One generation; returns the cycle count from the start edge to done being visible.
  task automatic run_gen(input logic [63:0] b, input bit stall, input int restart_at,
                         input logic [63:0] alt, output int cycles);
    bit got;
    @(negedge clk);
    board_in = b;
    start    = 1'b1;
    en       = 1'b1;
    cycles   = 0;
    got      = 1'b0;
    while (cycles < 400 && !got) begin
      @(negedge clk);
      cycles++;
      if (done) begin
        got   = 1'b1;
        start = 1'b1;
      end else begin
        start = 1'b0;
        en    = stall ? (cycles % 2 == 0) : 1'b1;
        if (cycles == restart_at) begin
          start    = 1'b1;
          board_in = alt;
        end
      end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL run_timeout: no done after %0d cycles", cycles);
    end
    @(negedge clk);
    start = 1'b0;
    check("done_single", {63'b0, done}, 64'd0);
    check("start_at_done_ignored", {63'b0, busy}, 64'd0);
  endtask

  localparam logic [63:0] BLINKER   = 64'h0000_0000_0000_0E00;
  localparam logic [63:0] BLINKER_N = 64'h0000_0000_0004_0404;
  localparam logic [63:0] BLOCK     = 64'h0000_0000_0000_0303;
  localparam logic [63:0] EDGE_LINE = 64'h0000_0000_0080_8080;
  localparam logic [63:0] EDGE_N    = 64'h0000_0000_0000_C000;

  initial begin
    int          cyc;
    int          k;
    logic [63:0] rnd;
    logic [2:0]  wrap_bits;

    rst = 1'b1; start = 1'b0; en = 1'b0; board_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_cnt", {58'b0, cnt}, 64'd0);
    check("rst_board_out", board_out, 64'd0);
    rst = 1'b0;

    check("model_blinker", life_next(BLINKER), BLINKER_N);
    check("model_block", life_next(BLOCK), BLOCK);
    check("model_edge", life_next(EDGE_LINE), EDGE_N);

    run_gen(BLINKER, 1'b0, -1, '0, cyc);
    check("blinker_latency", 64'(cyc), 64'd66);
    check("blinker_result", board_out, BLINKER_N);

    run_gen(BLOCK, 1'b0, -1, '0, cyc);
    check("block_result", board_out, BLOCK);

    run_gen(BLINKER, 1'b1, -1, '0, cyc);
    check("stall_latency", 64'(cyc), 64'd130);
    check("stall_result", board_out, BLINKER_N);

    run_gen(EDGE_LINE, 1'b0, -1, '0, cyc);
    check("edge_result", board_out, EDGE_N);
    wrap_bits = {board_out[24], board_out[8], board_out[0]};
    check("edge_no_wrap", {61'b0, wrap_bits}, 64'd0);

    run_gen(BLINKER, 1'b0, 30, 64'hFFFF_0000_FFFF_0000, cyc);
    check("busy_start_latency", 64'(cyc), 64'd66);
    check("busy_start_result", board_out, BLINKER_N);

    rnd = {$urandom, $urandom};
    run_gen(rnd, 1'b0, -1, '0, cyc);
    check("random_result", board_out, life_next(rnd));

    @(negedge clk);
    board_in = BLOCK; start = 1'b1; en = 1'b1;
    k = 0;
    @(negedge clk);
    start = 1'b0;
    while (cnt != 6'd20 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reset_reached_cnt20", {58'b0, cnt}, 64'd20);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_done", {63'b0, done}, 64'd0);
    check("midrst_board_out", board_out, 64'd0);
    check("midrst_cnt", {58'b0, cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_gen(BLINKER, 1'b0, -1, '0, cyc);
    check("post_rst_latency", 64'(cyc), 64'd66);
    check("post_rst_result", board_out, BLINKER_N);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
